mem_stage: RTL and testbench

Memory-stage controller for the five-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the byte-addressed combinational data memory. It accepts one operation at a time over a valid/ready handshake and decodes `funct3` into the memory's access size. It drives stores to memory for exactly one cycle, sign- or zero-extends load data, detects faults, and presents a registered result to writeback over a second valid/ready handshake.

---
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-stage controller: accepts one EX op at a time, performs at most one
// data-memory access for it, and holds a registered, fault-tagged result for WB.
module mem_stage #(
  parameter logic [31:0] MEM_BASE  = 32'h0100_0000,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,

  output logic [31:0] dmem_address,
  output logic        dmem_read_write,
  output logic [31:0] dmem_data_in,
  output logic [1:0]  dmem_access_size,
  input  logic [31:0] dmem_data_out,

  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_fault
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] FAULT_NONE       = 2'd0;
  localparam logic [1:0] FAULT_MISALIGNED = 2'd1;
  localparam logic [1:0] FAULT_RANGE      = 2'd2;
  localparam logic [1:0] FAULT_ILLEGAL    = 2'd3;

  // One past the last mapped byte, kept in 33 bits so an access near 2^32 cannot wrap into range.
  localparam logic [32:0] MEM_LIMIT = {1'b0, MEM_BASE} + 33'(MEM_DEPTH);

  logic [1:0]  state;
  logic        load_pending;
  logic [2:0]  load_funct3;

  logic        accept;
  logic        mem_op;
  logic        is_illegal;
  logic        is_misaligned;
  logic        is_out_of_range;
  logic [2:0]  access_bytes;
  logic [32:0] addr_ext;
  logic [32:0] access_end;
  logic [1:0]  fault;
  logic [31:0] load_value;

  assign ex_ready = (state == ST_IDLE);
  assign accept   = ex_valid && ex_ready;
  assign mem_op   = ex_mem_read || ex_mem_write;

  always_comb begin
    is_illegal = 1'b0;
    if (ex_mem_read && ex_mem_write)
      is_illegal = 1'b1;
    else if (ex_mem_read)
      is_illegal = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
    else if (ex_mem_write)
      is_illegal = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
  end

  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
    is_misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                    ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
    addr_ext        = {1'b0, ex_alu_result};
    access_end      = addr_ext + {30'd0, access_bytes};
    is_out_of_range = (addr_ext < {1'b0, MEM_BASE}) || (access_end > MEM_LIMIT);
  end

  always_comb begin
    fault = FAULT_NONE;
    if (mem_op) begin
      if (is_illegal)
        fault = FAULT_ILLEGAL;
      else if (is_misaligned)
        fault = FAULT_MISALIGNED;
      else if (is_out_of_range)
        fault = FAULT_RANGE;
    end
  end

  // Memory returns data with the addressed bytes in the low lanes.
  always_comb begin
    case (load_funct3)
      3'b000:  load_value = {{24{dmem_data_out[7]}}, dmem_data_out[7:0]};
      3'b100:  load_value = {24'd0, dmem_data_out[7:0]};
      3'b001:  load_value = {{16{dmem_data_out[15]}}, dmem_data_out[15:0]};
      3'b101:  load_value = {16'd0, dmem_data_out[15:0]};
      default: load_value = dmem_data_out;
    endcase
  end

  // dmem_read_write is raised on accept and cleared on the ACCESS edge, so a
  // store strobe is exactly one cycle regardless of later WB stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      load_pending     <= 1'b0;
      load_funct3      <= 3'd0;
      dmem_address     <= MEM_BASE;
      dmem_read_write  <= 1'b0;
      dmem_data_in     <= 32'd0;
      dmem_access_size <= 2'd0;
      wb_valid         <= 1'b0;
      wb_pc            <= 32'd0;
      wb_rd            <= 5'd0;
      wb_reg_write     <= 1'b0;
      wb_data          <= 32'd0;
      wb_fault         <= FAULT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wb_pc    <= ex_pc;
            wb_rd    <= ex_rd;
            wb_fault <= fault;
            if (mem_op && (fault == FAULT_NONE)) begin
              state            <= ST_ACCESS;
              dmem_address     <= ex_alu_result;
              dmem_access_size <= ex_funct3[1:0];
              dmem_data_in     <= ex_rs2_data;
              dmem_read_write  <= ex_mem_write;
              load_pending     <= ex_mem_read;
              load_funct3      <= ex_funct3;
              wb_reg_write     <= ex_mem_read && ex_reg_write;
              wb_data          <= 32'd0;
            end else begin
              // Faulted ops report their address; plain ALU ops pass their result.
              state        <= ST_RESP;
              wb_valid     <= 1'b1;
              wb_reg_write <= !mem_op && ex_reg_write;
              wb_data      <= ex_alu_result;
            end
          end
        end
        ST_ACCESS: begin
          dmem_read_write <= 1'b0;
          if (load_pending)
            wb_data <= load_value;
          wb_valid <= 1'b1;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized ops checked
// against a byte-level reference model of loads, stores and fault rules.
module tb_mem_stage;

  localparam logic [31:0] MEM_BASE  = 32'h0100_0000;
  localparam int unsigned MEM_DEPTH = 1048576;
  localparam int          WIN       = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_alu_result, ex_rs2_data;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [31:0] dmem_address;
  logic        dmem_read_write;
  logic [31:0] dmem_data_in;
  logic [1:0]  dmem_access_size;
  logic [31:0] dmem_data_out;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_pc;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [1:0]  wb_fault;

  int tests_run = 0;
  int failures  = 0;

  mem_stage #(.MEM_BASE(MEM_BASE), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .dmem_address(dmem_address), .dmem_read_write(dmem_read_write),
    .dmem_data_in(dmem_data_in), .dmem_access_size(dmem_access_size),
    .dmem_data_out(dmem_data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_fault(wb_fault)
  );

  always #5 clock = ~clock;

  // Combinational data memory covering the first WIN bytes of the mapped region.
  logic [7:0]  dmem [0:WIN+3];
  logic [31:0] rd_off;
  int          rd_idx;
  always_comb begin
    rd_off        = dmem_address - MEM_BASE;
    rd_idx        = 0;
    dmem_data_out = 32'd0;
    if (rd_off < 32'(WIN)) begin
      rd_idx        = int'(rd_off);
      dmem_data_out = {dmem[rd_idx+3], dmem[rd_idx+2], dmem[rd_idx+1], dmem[rd_idx]};
    end
  end

  always @(posedge clock) begin
    int wr_idx;
    if (dmem_read_write === 1'b1 && (dmem_address - MEM_BASE) < 32'(WIN)) begin
      wr_idx = int'(dmem_address - MEM_BASE);
      dmem[wr_idx] <= dmem_data_in[7:0];
      if (dmem_access_size != 2'd0) dmem[wr_idx+1] <= dmem_data_in[15:8];
      if (dmem_access_size == 2'd2) begin
        dmem[wr_idx+2] <= dmem_data_in[23:16];
        dmem[wr_idx+3] <= dmem_data_in[31:24];
      end
    end
  end

  typedef struct {
    logic [31:0] pc, alu, rs2;
    logic [2:0]  f3;
    logic        rd_en, wr_en, regw;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic [31:0] data, pc;
    logic [4:0]  rd;
    logic        regw;
    logic [1:0]  fault;
    int          lat, strobes;
  } exp_t;

  typedef struct {
    logic [31:0] data, pc, wr_addr, wr_data;
    logic [4:0]  rd;
    logic        regw;
    logic [1:0]  fault;
    int          lat, strobes;
    bit          timeout, unstable, busy_ready, ready_after;
  } obs_t;

  // Reference model: byte-addressed shadow memory and fault rules in plain arithmetic.
  logic [7:0] ref_mem [longint];

  function automatic logic [7:0] ref_byte(input longint a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic op_t mk(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                             input logic [2:0] f3, input logic rd_en, input logic wr_en,
                             input logic [4:0] rd, input logic regw);
    op_t op;
    op.pc = pc; op.alu = alu; op.rs2 = rs2; op.f3 = f3;
    op.rd_en = rd_en; op.wr_en = wr_en; op.rd = rd; op.regw = regw;
    return op;
  endfunction

  task automatic predict(input op_t op, output exp_t e);
    longint a, v;
    int     nb;
    bit     signed_ld;
    a = longint'(op.alu);
    e.pc = op.pc; e.rd = op.rd; e.fault = 2'd0; e.lat = 1; e.strobes = 0;
    e.data = op.alu; e.regw = op.regw;
    if (!op.rd_en && !op.wr_en) return;
    nb = (op.f3 % 4 == 0) ? 1 : (op.f3 % 4 == 1) ? 2 : 4;
    if (op.rd_en && op.wr_en)                                e.fault = 2'd3;
    else if (op.rd_en && (op.f3 == 3 || op.f3 >= 6))        e.fault = 2'd3;
    else if (op.wr_en && op.f3 > 2)                          e.fault = 2'd3;
    else if (a % nb != 0)                                    e.fault = 2'd1;
    else if (a < longint'(MEM_BASE) || a + nb > longint'(MEM_BASE) + longint'(MEM_DEPTH))
                                                             e.fault = 2'd2;
    if (e.fault != 2'd0) begin
      e.regw = 1'b0;
      return;
    end
    e.lat = 2;
    if (op.wr_en) begin
      for (int i = 0; i < nb; i++) ref_mem[a+i] = op.rs2[8*i +: 8];
      e.data = 32'd0; e.regw = 1'b0; e.strobes = 1;
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (longint'(ref_byte(a+i)) << (8*i));
      signed_ld = (op.f3 < 4);
      if (signed_ld && v >= (64'sd1 <<< (8*nb-1))) v = v - (64'sd1 <<< (8*nb));
      e.data = v[31:0];
    end
  endtask

  task automatic do_op(input op_t op, input int stall, output obs_t o);
    int n;
    o.data = 0; o.pc = 0; o.wr_addr = 0; o.wr_data = 0; o.rd = 0; o.regw = 0; o.fault = 0;
    o.lat = 0; o.strobes = 0; o.timeout = 0; o.unstable = 0; o.busy_ready = 0; o.ready_after = 0;
    n = 0;
    while (ex_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    if (ex_ready !== 1'b1) o.timeout = 1;
    ex_valid = 1'b1; ex_pc = op.pc; ex_alu_result = op.alu; ex_rs2_data = op.rs2;
    ex_funct3 = op.f3; ex_mem_read = op.rd_en; ex_mem_write = op.wr_en;
    ex_rd = op.rd; ex_reg_write = op.regw;
    @(posedge clock);
    @(negedge clock);
    ex_valid = 1'b0;
    o.lat = 1;
    while (wb_valid !== 1'b1 && o.lat < 10) begin
      if (dmem_read_write === 1'b1) begin
        o.strobes++; o.wr_addr = dmem_address; o.wr_data = dmem_data_in;
      end
      if (ex_ready !== 1'b0) o.busy_ready = 1;
      @(negedge clock);
      o.lat++;
    end
    if (wb_valid !== 1'b1) begin o.timeout = 1; return; end
    o.data = wb_data; o.pc = wb_pc; o.rd = wb_rd; o.regw = wb_reg_write; o.fault = wb_fault;
    for (int i = 0; i < stall; i++) begin
      if (dmem_read_write === 1'b1) o.strobes++;
      if (ex_ready !== 1'b0) o.busy_ready = 1;
      @(negedge clock);
      if ({wb_valid, wb_data, wb_pc, wb_rd, wb_reg_write, wb_fault} !==
          {1'b1, o.data, o.pc, o.rd, o.regw, o.fault}) o.unstable = 1;
    end
    if (dmem_read_write === 1'b1) o.strobes++;
    if (ex_ready !== 1'b0) o.busy_ready = 1;
    wb_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wb_ready = 1'b0;
    o.ready_after = (ex_ready === 1'b1) && (wb_valid === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({ex_ready, dmem_read_write, wb_valid, wb_reg_write, wb_fault, dmem_access_size} !== 8'b1000_0000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 10000000",
               {ex_ready, dmem_read_write, wb_valid, wb_reg_write, wb_fault, dmem_access_size});
    end
    tests_run++;
    if ({dmem_address, dmem_data_in} !== {MEM_BASE, 32'd0}) begin
      failures++;
      $display("[TB] FAIL reset_dmem: got addr %h data %h expected %h / 0", dmem_address, dmem_data_in, MEM_BASE);
    end
    tests_run++;
    if ({wb_pc, wb_rd, wb_data} !== 69'd0) begin
      failures++;
      $display("[TB] FAIL reset_wb: got pc %h rd %0d data %h expected zeros", wb_pc, wb_rd, wb_data);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_store_load();
    op_t op; exp_t e; obs_t o;
    op = mk(32'h100, 32'h0100_0010, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1, 5'd0, 1'b0);
    predict(op, e); do_op(op, 0, o);
    tests_run++;
    if (o.strobes !== 1 || o.wr_addr !== 32'h0100_0010 || o.wr_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL sw_strobe: got %0d cycles addr %h data %h expected 1 / 01000010 / deadbeef",
               o.strobes, o.wr_addr, o.wr_data);
    end
    tests_run++;
    if (o.timeout || o.lat !== 2 || o.regw !== 1'b0 || o.data !== 32'd0 || o.fault !== 2'd0) begin
      failures++;
      $display("[TB] FAIL sw_result: got lat %0d regw %b data %h fault %0d expected 2 / 0 / 0 / 0",
               o.lat, o.regw, o.data, o.fault);
    end
    op = mk(32'h104, 32'h0100_0010, 32'h0, 3'b010, 1'b1, 1'b0, 5'd7, 1'b1);
    predict(op, e); do_op(op, 0, o);
    tests_run++;
    if (o.timeout || o.data !== 32'hDEAD_BEEF || o.regw !== 1'b1 || o.fault !== 2'd0 ||
        o.strobes !== 0 || o.lat !== 2 || o.rd !== 5'd7 || o.pc !== 32'h104) begin
      failures++;
      $display("[TB] FAIL lw_result: got data %h regw %b fault %0d strobes %0d lat %0d expected deadbeef / 1 / 0 / 0 / 2",
               o.data, o.regw, o.fault, o.strobes, o.lat);
    end
    op = mk(32'h108, 32'h1234_5678, 32'h0, 3'b111, 1'b0, 1'b0, 5'd3, 1'b1);
    predict(op, e); do_op(op, 0, o);
    tests_run++;
    if (o.timeout || o.data !== 32'h1234_5678 || o.regw !== 1'b1 || o.lat !== 1 || o.fault !== 2'd0) begin
      failures++;
      $display("[TB] FAIL alu_passthru: got data %h regw %b lat %0d fault %0d expected 12345678 / 1 / 1 / 0",
               o.data, o.regw, o.lat, o.fault);
    end
  endtask

  task automatic test_byte_ext();
    op_t op; exp_t e; obs_t o;
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h0100_0003, 32'h0100_0003, 32'h0100_0002, 32'h0100_0002};
    logic [31:0] want [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_8000};
    op = mk(32'h200, 32'h0100_0003, 32'hABCD_EF80, 3'b000, 1'b0, 1'b1, 5'd0, 1'b0);
    predict(op, e); do_op(op, 0, o);
    tests_run++;
    if (o.strobes !== 1 || o.wr_data !== 32'hABCD_EF80) begin
      failures++;
      $display("[TB] FAIL sb_strobe: got %0d cycles data %h expected 1 / abcdef80", o.strobes, o.wr_data);
    end
    for (int i = 0; i < 4; i++) begin
      op = mk(32'h204 + 32'(4*i), adrs[i], 32'h0, f3s[i], 1'b1, 1'b0, 5'd9, 1'b1);
      predict(op, e); do_op(op, 0, o);
      tests_run++;
      if (o.timeout || o.data !== want[i] || o.fault !== 2'd0) begin
        failures++;
        $display("[TB] FAIL load_ext_f3_%0d: got data %h fault %0d expected %h / 0", f3s[i], o.data, o.fault, want[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    op_t op; exp_t e; obs_t o;
    op = mk(32'h300, 32'h0100_0001, 32'h0, 3'b001, 1'b1, 1'b0, 5'd4, 1'b1);
    predict(op, e); do_op(op, 0, o);
    tests_run++;
    if (o.timeout || o.fault !== 2'd1 || o.regw !== 1'b0 || o.strobes !== 0 ||
        o.data !== 32'h0100_0001 || o.lat !== 1) begin
      failures++;
      $display("[TB] FAIL lh_misaligned: got fault %0d regw %b strobes %0d data %h lat %0d expected 1 / 0 / 0 / 01000001 / 1",
               o.fault, o.regw, o.strobes, o.data, o.lat);
    end
    op = mk(32'h304, 32'h0100_0006, 32'h5555_5555, 3'b010, 1'b0, 1'b1, 5'd0, 1'b0);
    predict(op, e); do_op(op, 0, o);
    tests_run++;
    if (o.timeout || o.fault !== 2'd1 || o.strobes !== 0) begin
      failures++;
      $display("[TB] FAIL sw_misaligned: got fault %0d strobes %0d expected 1 / 0", o.fault, o.strobes);
    end
  endtask

  task automatic test_out_of_range();
    op_t op; exp_t e; obs_t o;
    logic [31:0] adrs [5] = '{32'h00FF_FFFC, 32'h0110_0000, 32'hFFFF_FFFC, 32'h010F_FFFC, 32'h010F_FFFE};
    logic [1:0]  want [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      op = mk(32'h400 + 32'(4*i), adrs[i], 32'h0, 3'b010, 1'b1, 1'b0, 5'd5, 1'b1);
      predict(op, e); do_op(op, 0, o);
      tests_run++;
      if (o.timeout || o.fault !== want[i] || o.fault !== e.fault || o.data !== e.data || o.regw !== e.regw) begin
        failures++;
        $display("[TB] FAIL lw_range_%h: got fault %0d data %h regw %b expected %0d / %h / %b",
                 adrs[i], o.fault, o.data, o.regw, want[i], e.data, e.regw);
      end
    end
  endtask

  task automatic test_illegal();
    op_t op; exp_t e; obs_t o;
    op_t ops [3];
    ops[0] = mk(32'h500, 32'h0100_0001, 32'h0, 3'b011, 1'b1, 1'b0, 5'd6, 1'b1);
    ops[1] = mk(32'h504, 32'h0100_0020, 32'h1, 3'b010, 1'b1, 1'b1, 5'd6, 1'b1);
    ops[2] = mk(32'h508, 32'h0100_0020, 32'h1, 3'b100, 1'b0, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      predict(ops[i], e); do_op(ops[i], 0, o);
      tests_run++;
      if (o.timeout || o.fault !== 2'd3 || o.regw !== 1'b0 || o.strobes !== 0 || o.data !== ops[i].alu) begin
        failures++;
        $display("[TB] FAIL illegal_%0d: got fault %0d regw %b strobes %0d data %h expected 3 / 0 / 0 / %h",
                 i, o.fault, o.regw, o.strobes, o.data, ops[i].alu);
      end
    end
    op = mk(32'h50C, 32'hFFFF_FFFF, 32'h0, 3'b011, 1'b0, 1'b0, 5'd2, 1'b0);
    predict(op, e); do_op(op, 0, o);
    tests_run++;
    if (o.timeout || o.fault !== 2'd0 || o.data !== 32'hFFFF_FFFF || o.regw !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nonmem_unchecked: got fault %0d data %h regw %b expected 0 / ffffffff / 0", o.fault, o.data, o.regw);
    end
  endtask

  task automatic test_backpressure();
    op_t op; exp_t e; obs_t o;
    op = mk(32'h600, 32'h0100_0010, 32'h0, 3'b010, 1'b1, 1'b0, 5'd11, 1'b1);
    predict(op, e); do_op(op, 5, o);
    tests_run++;
    if (o.timeout || o.unstable || o.data !== 32'hDEAD_BEEF || o.pc !== 32'h600 || o.rd !== 5'd11) begin
      failures++;
      $display("[TB] FAIL stall_stable: got unstable %0d data %h pc %h rd %0d expected 0 / deadbeef / 600 / 11",
               o.unstable, o.data, o.pc, o.rd);
    end
    tests_run++;
    if (o.busy_ready || !o.ready_after) begin
      failures++;
      $display("[TB] FAIL stall_ready: got busy_ready %0d ready_after %0d expected 0 / 1", o.busy_ready, o.ready_after);
    end
    op = mk(32'h604, 32'h0100_0040, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 5'd0, 1'b0);
    predict(op, e); do_op(op, 4, o);
    tests_run++;
    if (o.timeout || o.strobes !== 1 || o.unstable) begin
      failures++;
      $display("[TB] FAIL stall_store_strobe: got %0d cycles unstable %0d expected 1 / 0", o.strobes, o.unstable);
    end
  endtask

  task automatic test_reset_in_access();
    op_t op; exp_t e; obs_t o;
    while (ex_ready !== 1'b1) @(negedge clock);
    ex_valid = 1'b1; ex_pc = 32'h700; ex_alu_result = 32'h0100_0100; ex_rs2_data = 32'h1234_5678;
    ex_funct3 = 3'b010; ex_mem_read = 1'b0; ex_mem_write = 1'b1; ex_rd = 5'd0; ex_reg_write = 1'b0;
    @(posedge clock); @(negedge clock);
    ex_valid = 1'b0;
    tests_run++;
    if (dmem_read_write !== 1'b1) begin
      failures++;
      $display("[TB] FAIL access_strobe_before_reset: got %b expected 1", dmem_read_write);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (dmem_read_write !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_in_access: got rw %b ready %b wb_valid %b expected 0 / 1 / 0",
               dmem_read_write, ex_ready, wb_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    ex_valid = 1'b1; ex_pc = 32'h704; ex_alu_result = 32'h0000_00AA; ex_funct3 = 3'b000;
    ex_mem_write = 1'b0; ex_rd = 5'd1; ex_reg_write = 1'b1;
    @(posedge clock); @(negedge clock);
    ex_valid = 1'b0;
    tests_run++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_00AA) begin
      failures++;
      $display("[TB] FAIL resp_before_reset: got wb_valid %b data %h expected 1 / 000000aa", wb_valid, wb_data);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0 || ex_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_resp: got wb_valid %b data %h ready %b expected 0 / 0 / 1", wb_valid, wb_data, ex_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    op = mk(32'h708, 32'h0100_0010, 32'h0, 3'b010, 1'b1, 1'b0, 5'd12, 1'b1);
    predict(op, e); do_op(op, 0, o);
    tests_run++;
    if (o.timeout || o.data !== e.data || o.fault !== 2'd0) begin
      failures++;
      $display("[TB] FAIL recover_after_reset: got data %h fault %0d expected %h / 0", o.data, o.fault, e.data);
    end
  endtask

  task automatic test_random();
    op_t op; exp_t e; obs_t o;
    int kind, region;
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      region = $urandom_range(0, 9);
      if (region < 7)      addr = MEM_BASE + 32'($urandom_range(0, WIN - 5));
      else if (region == 7) addr = 32'($urandom_range(0, 32'h00FF_FFFF));
      else if (region == 8) addr = 32'h0110_0000 + 32'($urandom_range(0, 32'hFFFF));
      else                  addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      kind = $urandom_range(0, 9);
      op = mk($urandom, addr, $urandom, 3'($urandom_range(0, 7)),
              kind < 4 || kind == 9, kind >= 4 && kind < 8 || kind == 9,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if (kind < 6 && $urandom_range(0, 3) != 0) op.f3 = (kind < 4) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
      if (kind < 4 && $urandom_range(0, 1) == 1) op.f3 = op.f3 | 3'b100;
      if (op.f3 == 3'b110 && kind < 4 && $urandom_range(0, 1) == 1) op.f3 = 3'b101;
      predict(op, e);
      do_op(op, $urandom_range(0, 2), o);
      tests_run++;
      if (o.timeout || o.fault !== e.fault || o.data !== e.data || o.regw !== e.regw ||
          o.pc !== e.pc || o.rd !== e.rd || o.lat !== e.lat || o.strobes !== e.strobes ||
          o.unstable || o.busy_ready || !o.ready_after) begin
        failures++;
        $display("[TB] FAIL random_%0d: addr %h f3 %0d r%b w%b got fault %0d data %h regw %b lat %0d strobes %0d to %0d expected %0d / %h / %b / %0d / %0d",
                 n, op.alu, op.f3, op.rd_en, op.wr_en, o.fault, o.data, o.regw, o.lat, o.strobes, o.timeout,
                 e.fault, e.data, e.regw, e.lat, e.strobes);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < WIN + 4; i++) dmem[i] = 8'h00;
    reset = 1'b1; ex_valid = 1'b0; wb_ready = 1'b0;
    ex_pc = 0; ex_alu_result = 0; ex_rs2_data = 0; ex_funct3 = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_rd = 0; ex_reg_write = 0;
    test_reset();
    test_store_load();
    test_byte_ext();
    test_misaligned();
    test_out_of_range();
    test_illegal();
    test_backpressure();
    test_reset_in_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
